// File: rtl/ram2p8d256w_fifo_ctrl.sv
// FIFO controller over an 8x256 two-port RAM with a 2-entry output stage hiding the read latency.
// Latency: push to popValid is 3 cycles when empty; pushReady drops only when the RAM holds 8 entries.
module ram2p8d256w_fifo_ctrl (
  input  logic         clockCore,
  input  logic         resetCoreN,
  input  logic         flush,
  input  logic         pushValid,
  output logic         pushReady,
  input  logic [255:0] pushData,
  output logic         popValid,
  input  logic         popReady,
  output logic [255:0] popData,
  output logic [3:0]   level,
  output logic         ramEnableWrite,
  output logic [2:0]   ramAddressWrite,
  output logic [255:0] ramWriteData,
  output logic         ramEnableRead,
  output logic [2:0]   ramAddressRead,
  input  logic [255:0] ramReadData
);

  logic [2:0]   wrPtr;
  logic [2:0]   rdPtr;
  logic [3:0]   ramCount;
  logic         rdPending;
  logic [1:0]   stageCount;
  logic [255:0] stage0;
  logic [255:0] stage1;

  logic         pushFire;
  logic         popFire;
  logic         readIssue;
  logic [2:0]   stageClaim;
  logic [1:0]   stageAfterPop;

  assign pushReady = (ramCount != 4'd8);
  assign popValid  = (stageCount != 2'd0);
  assign popData   = stage0;

  assign pushFire = pushValid && pushReady && !flush;
  assign popFire  = popValid && popReady && !flush;

  // Slots already spoken for once this cycle's pop leaves; a new read only issues if one stays free.
  assign stageClaim    = {1'b0, stageCount} + {2'b00, rdPending} - {2'b00, popFire};
  assign readIssue     = (ramCount != 4'd0) && (stageClaim < 3'd2) && !flush;
  assign stageAfterPop = stageCount - {1'b0, popFire};

  assign level = ramCount + {3'b000, rdPending} + {2'b00, stageCount};

  assign ramEnableWrite  = pushFire;
  assign ramAddressWrite = wrPtr;
  assign ramWriteData    = pushData;
  assign ramEnableRead   = readIssue;
  assign ramAddressRead  = rdPtr;

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      wrPtr      <= 3'd0;
      rdPtr      <= 3'd0;
      ramCount   <= 4'd0;
      rdPending  <= 1'b0;
      stageCount <= 2'd0;
    end else if (flush) begin
      wrPtr      <= 3'd0;
      rdPtr      <= 3'd0;
      ramCount   <= 4'd0;
      rdPending  <= 1'b0;
      stageCount <= 2'd0;
    end else begin
      if (pushFire) begin
        wrPtr <= wrPtr + 3'd1;
      end
      if (readIssue) begin
        rdPtr <= rdPtr + 3'd1;
      end
      ramCount   <= ramCount + {3'b000, pushFire} - {3'b000, readIssue};
      rdPending  <= readIssue;
      stageCount <= stageAfterPop + {1'b0, rdPending};
    end
  end

  // Returning RAM data lands in the first slot left free after this cycle's pop.
  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      stage0 <= '0;
      stage1 <= '0;
    end else if (!flush) begin
      if (rdPending && (stageAfterPop == 2'd0)) begin
        stage0 <= ramReadData;
      end else if (popFire) begin
        stage0 <= stage1;
      end
      if (rdPending && (stageAfterPop == 2'd1)) begin
        stage1 <= ramReadData;
      end
    end
  end

endmodule

// File: tb/tb_ram2p8d256w_fifo_ctrl.sv
// Bench for ram2p8d256w_fifo_ctrl: RAM model, queue scoreboard, directed and random traffic.
module tb_ram2p8d256w_fifo_ctrl;

  logic         clockCore = 1'b0;
  logic         resetCoreN;
  logic         flush;
  logic         pushValid;
  logic         pushReady;
  logic [255:0] pushData;
  logic         popValid;
  logic         popReady;
  logic [255:0] popData;
  logic [3:0]   level;
  logic         ramEnableWrite;
  logic [2:0]   ramAddressWrite;
  logic [255:0] ramWriteData;
  logic         ramEnableRead;
  logic [2:0]   ramAddressRead;
  logic [255:0] ramReadData = '0;

  always #5 clockCore = ~clockCore;

  ram2p8d256w_fifo_ctrl dut (
    .clockCore(clockCore),
    .resetCoreN(resetCoreN),
    .flush(flush),
    .pushValid(pushValid),
    .pushReady(pushReady),
    .pushData(pushData),
    .popValid(popValid),
    .popReady(popReady),
    .popData(popData),
    .level(level),
    .ramEnableWrite(ramEnableWrite),
    .ramAddressWrite(ramAddressWrite),
    .ramWriteData(ramWriteData),
    .ramEnableRead(ramEnableRead),
    .ramAddressRead(ramAddressRead),
    .ramReadData(ramReadData)
  );

  // Two-port RAM with one cycle of read latency.
  logic [255:0] mem [8];
  always @(posedge clockCore) begin
    if (ramEnableWrite) mem[ramAddressWrite] <= ramWriteData;
    if (ramEnableRead) ramReadData <= mem[ramAddressRead];
  end

  int total = 0;
  int bad = 0;
  logic [255:0] expQ[$];
  int nextWr = 0;
  int nextRd = 0;
  int wrWraps = 0;
  int rdWraps = 0;

  task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Push side: records accepted data, checks occupancy and RAM address sequencing.
  always @(negedge clockCore) begin
    if (!resetCoreN) begin
      expQ.delete();
      nextWr = 0;
      nextRd = 0;
    end else begin
      chk(level == 4'(expQ.size()), "level", 256'(level), 256'(expQ.size()));
      if (!pushReady) chk(level >= 4'd8, "readyLowButRoom", 256'(level), 256'd8);
      if (flush) begin
        chk(!ramEnableWrite && !ramEnableRead, "flushEnables",
            256'({ramEnableWrite, ramEnableRead}), 256'd0);
        expQ.delete();
        nextWr = 0;
        nextRd = 0;
      end else begin
        chk(ramEnableWrite == (pushValid && pushReady), "wrEnable",
            256'(ramEnableWrite), 256'(pushValid && pushReady));
        if (pushValid && pushReady) expQ.push_back(pushData);
        if (ramEnableWrite) begin
          chk(ramAddressWrite == 3'(nextWr), "wrAddr", 256'(ramAddressWrite), 256'(nextWr));
          if (nextWr == 7) wrWraps++;
          nextWr = (nextWr + 1) % 8;
        end
        if (ramEnableRead) begin
          chk(ramAddressRead == 3'(nextRd), "rdAddr", 256'(ramAddressRead), 256'(nextRd));
          if (nextRd == 7) rdWraps++;
          nextRd = (nextRd + 1) % 8;
        end
      end
    end
  end

  // Pop side: every accepted output must be the oldest outstanding push.
  always @(negedge clockCore) begin
    #1;
    if (resetCoreN && !flush && popValid && popReady) begin
      chk(expQ.size() != 0, "popUnderflow", 256'(expQ.size()), 256'd1);
      if (expQ.size() != 0) begin
        chk(popData == expQ[0], "popData", popData, expQ[0]);
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  task automatic waitDrain(input string name);
    int n = 0;
    while (level != 4'd0 && n < 60) begin
      @(negedge clockCore);
      n++;
    end
    chk(level == 4'd0, name, 256'(level), 256'd0);
  endtask

  logic [255:0] pat;
  int v;

  initial begin
    resetCoreN = 1'b0;
    flush = 1'b0;
    pushValid = 1'b0;
    pushData = '0;
    popReady = 1'b0;
    @(negedge clockCore);
    chk({pushReady, popValid, level, ramEnableWrite, ramEnableRead} == 8'h80, "inReset",
        256'({pushReady, popValid, level, ramEnableWrite, ramEnableRead}), 256'h80);
    repeat (2) @(posedge clockCore);
    #1 resetCoreN = 1'b1;

    // Idle after reset
    for (int c = 0; c < 20; c++) begin
      @(negedge clockCore);
      chk({pushReady, popValid, level, ramEnableWrite, ramEnableRead} == 8'h80, "idle",
          256'({pushReady, popValid, level, ramEnableWrite, ramEnableRead}), 256'h80);
    end
    chk(popData == '0, "resetPopData", popData, 256'd0);

    // Single entry latency
    pat = {{31{8'hA5}}, 8'h01};
    @(posedge clockCore); #1;
    pushValid = 1'b1;
    pushData = pat;
    popReady = 1'b1;
    @(negedge clockCore);
    chk(ramEnableWrite, "singlePush", 256'(ramEnableWrite), 256'd1);
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clockCore);
      chk(popValid == (k == 3), "singleValid", 256'(popValid), 256'(k == 3));
      chk(level == ((k < 4) ? 4'd1 : 4'd0), "singleLevel", 256'(level), 256'((k < 4) ? 1 : 0));
      if (k == 3) chk(popData == pat, "singleData", popData, pat);
    end

    // Fill to full with the consumer stalled
    @(posedge clockCore); #1;
    popReady = 1'b0;
    v = 0;
    pushValid = 1'b1;
    pushData = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clockCore);
      if (pushValid && pushReady) v++;
      @(posedge clockCore); #1;
      pushData = 256'(v);
      pushValid = (v < 12);
    end
    @(negedge clockCore);
    chk(v == 10, "fillAccepts", 256'(v), 256'd10);
    chk(level == 4'd10, "fillLevel", 256'(level), 256'd10);
    chk(!pushReady, "fillReady", 256'(pushReady), 256'd0);
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    repeat (3) begin
      @(negedge clockCore);
      chk(!ramEnableRead, "fullNoIssue", 256'(ramEnableRead), 256'd0);
    end
    @(posedge clockCore); #1;
    popReady = 1'b1;
    @(negedge clockCore);
    chk(ramEnableRead && !pushReady, "firstIssue", 256'({ramEnableRead, pushReady}), 256'b10);
    @(negedge clockCore);
    chk(pushReady, "readyBack", 256'(pushReady), 256'd1);
    waitDrain("fillDrain");

    // Back-to-back streaming across pointer wraps
    begin
      int w0;
      int r0;
      w0 = wrWraps;
      r0 = rdWraps;
      @(posedge clockCore); #1;
      popReady = 1'b1;
      fork
        begin
          for (int i = 0; i < 100; i++) begin
            pushValid = 1'b1;
            pushData = 256'(1000 + i);
            @(posedge clockCore); #1;
          end
          pushValid = 1'b0;
        end
        begin
          int k;
          int run;
          k = 0;
          run = 0;
          @(negedge clockCore);
          while (!popValid && k < 20) begin
            @(negedge clockCore);
            k++;
          end
          chk(k == 3, "streamLatency", 256'(k), 256'd3);
          while (popValid && run < 200) begin
            run++;
            @(negedge clockCore);
          end
          chk(run == 100, "streamContiguous", 256'(run), 256'd100);
        end
      join
      waitDrain("streamDrain");
      chk(wrWraps - w0 >= 12, "wrWraps", 256'(wrWraps - w0), 256'd12);
      chk(rdWraps - r0 >= 12, "rdWraps", 256'(rdWraps - r0), 256'd12);
    end

    // Random handshakes on both sides
    for (int c = 0; c < 2000; c++) begin
      @(posedge clockCore); #1;
      pushValid = 1'($urandom_range(0, 1));
      popReady = 1'($urandom_range(0, 1));
      pushData = rnd256();
    end
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    popReady = 1'b1;
    waitDrain("randomDrain");

    // Flush with six entries held and a read in flight
    @(posedge clockCore); #1;
    popReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pushValid = 1'b1;
      pushData = 256'(500 + i);
      @(posedge clockCore); #1;
    end
    pushValid = 1'b0;
    repeat (4) @(negedge clockCore);
    chk(level == 4'd6, "preFlushLevel", 256'(level), 256'd6);
    @(posedge clockCore); #1;
    pushValid = 1'b1;
    pushData = 256'd506;
    popReady = 1'b1;
    @(negedge clockCore);
    chk(ramEnableRead, "flushSetupIssue", 256'(ramEnableRead), 256'd1);
    @(posedge clockCore); #1;
    flush = 1'b1;
    pushData = 256'd777;
    @(negedge clockCore);
    chk(level == 4'd6, "flushCycleLevel", 256'(level), 256'd6);
    @(posedge clockCore); #1;
    flush = 1'b0;
    pushValid = 1'b0;
    popReady = 1'b0;
    @(negedge clockCore);
    chk(level == 4'd0 && !popValid, "afterFlush", 256'({level, popValid}), 256'd0);
    @(posedge clockCore); #1;
    pushValid = 1'b1;
    pushData = 256'h1;
    popReady = 1'b1;
    @(posedge clockCore); #1;
    pushValid = 1'b0;
    begin
      int n = 0;
      @(negedge clockCore);
      while (!popValid && n < 10) begin
        @(negedge clockCore);
        n++;
      end
      chk(popValid && popData == 256'h1, "postFlushData", popData, 256'h1);
    end
    waitDrain("flushDrain");

    // Asynchronous reset in the middle of a cycle
    @(posedge clockCore); #1;
    popReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pushValid = 1'b1;
      pushData = rnd256();
      @(posedge clockCore); #1;
    end
    pushValid = 1'b0;
    repeat (3) @(posedge clockCore);
    #2 resetCoreN = 1'b0;
    #1;
    chk({pushReady, popValid, level, ramEnableWrite, ramEnableRead} == 8'h80, "midReset",
        256'({pushReady, popValid, level, ramEnableWrite, ramEnableRead}), 256'h80);
    chk(popData == '0, "midResetData", popData, 256'd0);
    repeat (2) @(posedge clockCore);
    #1 resetCoreN = 1'b1;
    repeat (2) @(negedge clockCore);
    chk(level == 4'd0 && pushReady, "afterReset", 256'({level, pushReady}), 256'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
